sobel_line_delay_ctrl: RTL and testbench



---
 rtl/sobel_line_delay_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sobel_line_delay_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_line_delay_ctrl.sv
// Sobel line-buffer sequencer: fills the FIFO with one line, then streams a current/previous-line tap pair.
// Optional macro SOBEL_LDC_LINE_CNT_EN enables the saturating completed-line counter on line_cnt.
module sobel_line_delay_ctrl #(
  parameter int DATA_W     = 8,
  parameter int LINE_W     = 640,
  parameter int FRAME_H    = 480,
  parameter int FLUSH_IDLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  input  logic              in_sof,
  output logic              in_rdy,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_wr_en,
  input  logic              fifo_wr_vld,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] out_cur,
  output logic [DATA_W-1:0] out_prev,
  output logic              out_vld,
  output logic              out_eol,
  output logic              busy,
  output logic              err_ovf,
  output logic              err_udf,
  input  logic              err_clr,
  output logic [15:0]       line_cnt
);

  localparam int COL_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int ROW_W  = $clog2(FRAME_H + 1);
  localparam int IDLE_W = $clog2(FLUSH_IDLE + 1);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(FRAME_H - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_IDLE - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_FLUSH  = 2'd3;

  logic [1:0]        state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [IDLE_W-1:0] idle_cnt;

  logic in_line;
  logic premature;
  logic accept;
  logic stream_beat;
  logic ovf_set;
  logic udf_set;

  assign in_line     = (state == ST_FILL) || (state == ST_STREAM);
  // A start-of-frame inside a line is refused so it can restart the frame cleanly from IDLE.
  assign premature   = in_line & in_vld & in_sof;
  assign in_rdy      = (state != ST_FLUSH) & ~premature;
  assign accept      = in_vld & in_rdy;
  assign stream_beat = accept & (state == ST_STREAM);

  assign fifo_wr_data = in_data;
  assign fifo_wr_en   = accept & (in_line | in_sof);
  assign fifo_rd_en   = stream_beat | (state == ST_FLUSH);
  assign busy         = (state != ST_IDLE);

  assign ovf_set = fifo_wr_en & ~fifo_wr_vld;
  assign udf_set = stream_beat & ~fifo_rd_vld;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      col      <= '0;
      row      <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && in_sof) begin
            col   <= COL_W'(1);
            row   <= '0;
            state <= ST_FILL;
          end
        end
        ST_FILL, ST_STREAM: begin
          if (premature) begin
            state <= ST_FLUSH;
          end else if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + ROW_W'(1);
              if (state == ST_FILL)     state <= ST_STREAM;
              else if (row == ROW_LAST) state <= ST_FLUSH;
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        default: begin
          // Drain until the FIFO has reported empty for FLUSH_IDLE consecutive cycles.
          if (fifo_rd_vld) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            idle_cnt <= '0;
            col      <= '0;
            row      <= '0;
            state    <= ST_IDLE;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cur  <= '0;
      out_prev <= '0;
      out_vld  <= 1'b0;
      out_eol  <= 1'b0;
    end else if (stream_beat) begin
      out_cur  <= in_data;
      out_prev <= fifo_rd_data;
      out_vld  <= fifo_rd_vld;
      out_eol  <= fifo_rd_vld & (col == COL_LAST);
    end else begin
      out_vld  <= 1'b0;
      out_eol  <= 1'b0;
    end
  end

  // Set wins over a simultaneous clear so no error event is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      err_ovf <= ovf_set | (err_ovf & ~err_clr);
      err_udf <= udf_set | (err_udf & ~err_clr);
    end
  end

`ifdef SOBEL_LDC_LINE_CNT_EN
  logic line_done;
  assign line_done = accept & in_line & (col == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt <= '0;
    end else if (line_done && (line_cnt != 16'hFFFF)) begin
      line_cnt <= line_cnt + 16'd1;
    end
  end
`else
  assign line_cnt = '0;
`endif

endmodule

// File: tb/tb_sobel_line_delay_ctrl.sv
// Directed bench for sobel_line_delay_ctrl with a small behavioural FIFO (prefetched head, drop-on-full).
// Uses a shortened geometry (8 x 6 pixels) so full frames stay short.
module tb_sobel_line_delay_ctrl;

  localparam int DATA_W     = 8;
  localparam int LINE_W     = 8;
  localparam int FRAME_H    = 6;
  localparam int FLUSH_IDLE = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_vld;
  logic              in_sof;
  logic              in_rdy;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              fifo_wr_en;
  logic              fifo_wr_vld;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_vld;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] out_cur;
  logic [DATA_W-1:0] out_prev;
  logic              out_vld;
  logic              out_eol;
  logic              busy;
  logic              err_ovf;
  logic              err_udf;
  logic              err_clr;
  logic [15:0]       line_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sobel_line_delay_ctrl #(
    .DATA_W(DATA_W), .LINE_W(LINE_W), .FRAME_H(FRAME_H), .FLUSH_IDLE(FLUSH_IDLE)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_vld(in_vld), .in_sof(in_sof), .in_rdy(in_rdy),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .fifo_wr_vld(fifo_wr_vld),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(fifo_rd_en),
    .out_cur(out_cur), .out_prev(out_prev), .out_vld(out_vld), .out_eol(out_eol),
    .busy(busy), .err_ovf(err_ovf), .err_udf(err_udf), .err_clr(err_clr),
    .line_cnt(line_cnt)
  );

  // Behavioural 16-deep FIFO; force_* let tests fake an empty head or a full FIFO.
  logic [DATA_W-1:0] fmem [16];
  logic [3:0]        f_wp;
  logic [3:0]        f_rp;
  logic [4:0]        f_cnt;
  logic              force_rd_inv;
  logic              force_full;
  logic              do_pop;
  logic              do_push;

  assign fifo_rd_vld  = (f_cnt != 5'd0) & ~force_rd_inv;
  assign fifo_wr_vld  = (f_cnt != 5'd16) & ~force_full;
  assign fifo_rd_data = fmem[f_rp];
  assign do_pop       = fifo_rd_en & fifo_rd_vld;
  assign do_push      = fifo_wr_en & fifo_wr_vld;

  always @(posedge clk) begin
    if (rst) begin
      f_wp  <= 4'd0;
      f_rp  <= 4'd0;
      f_cnt <= 5'd0;
    end else begin
      if (do_push) begin
        fmem[f_wp] <= fifo_wr_data;
        f_wp       <= f_wp + 4'd1;
      end
      if (do_pop) f_rp <= f_rp + 4'd1;
      f_cnt <= f_cnt + {4'd0, do_push} - {4'd0, do_pop};
    end
  end

  function automatic logic [DATA_W-1:0] pix(input int base, input int idx);
    return DATA_W'(base + (idx % LINE_W) + 16 * (idx / LINE_W));
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_vld = 1'b0; in_sof = 1'b0; in_data = '0; err_clr = 1'b0;
    force_rd_inv = 1'b0; force_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives frame beats first..last-1 back to back and checks the output of each previous beat.
  task automatic stream_beats(input int first, input int last, input int base, output int n_out);
    int j;
    n_out = 0;
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      if (i > first) begin
        j = i - 1;
        checks++;
        if (out_vld !== logic'(j >= LINE_W)) begin
          failures++; $display("FAIL stream_vld beat %0d: got %0b want %0b", j, out_vld, j >= LINE_W);
        end
        if (j >= LINE_W) begin
          n_out++;
          checks++;
          if (out_cur !== pix(base, j)) begin
            failures++; $display("FAIL stream_cur beat %0d: got %0h want %0h", j, out_cur, pix(base, j));
          end
          checks++;
          if (out_prev !== pix(base, j - LINE_W)) begin
            failures++; $display("FAIL stream_prev beat %0d: got %0h want %0h", j, out_prev, pix(base, j - LINE_W));
          end
          checks++;
          if (out_eol !== logic'((j % LINE_W) == LINE_W - 1)) begin
            failures++; $display("FAIL stream_eol beat %0d: got %0b", j, out_eol);
          end
        end
      end
      if (i < last) begin
        in_vld = 1'b1; in_sof = (i == 0); in_data = pix(base, i);
        #1;
        checks++;
        if (in_rdy !== 1'b1 || fifo_wr_en !== 1'b1) begin
          failures++; $display("FAIL stream_accept beat %0d: rdy=%0b wr_en=%0b want 1/1", i, in_rdy, fifo_wr_en);
        end
        checks++;
        if (fifo_rd_en !== logic'(i >= LINE_W)) begin
          failures++; $display("FAIL stream_rd_en beat %0d: got %0b want %0b", i, fifo_rd_en, i >= LINE_W);
        end
      end else begin
        in_vld = 1'b0; in_sof = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({out_cur, out_prev} !== '0) begin
      failures++; $display("FAIL rst_data: got %0h/%0h want 0/0", out_cur, out_prev);
    end
    checks++;
    if ({out_vld, out_eol, busy, err_ovf, err_udf} !== 5'b0) begin
      failures++; $display("FAIL rst_flags: got %05b want 00000", {out_vld, out_eol, busy, err_ovf, err_udf});
    end
    checks++;
    if (line_cnt !== 16'd0) begin
      failures++; $display("FAIL rst_line_cnt: got %0d want 0", line_cnt);
    end
    checks++;
    if ({in_rdy, fifo_wr_en, fifo_rd_en} !== 3'b100) begin
      failures++; $display("FAIL rst_comb: got rdy/wr/rd %03b want 100", {in_rdy, fifo_wr_en, fifo_rd_en});
    end
    // Non-sof beats in IDLE are accepted and dropped.
    in_vld = 1'b1; in_sof = 1'b0; in_data = 8'h55;
    #1;
    checks++;
    if ({in_rdy, fifo_wr_en} !== 2'b10) begin
      failures++; $display("FAIL idle_discard_comb: got rdy/wr %02b want 10", {in_rdy, fifo_wr_en});
    end
    @(negedge clk);
    in_vld = 1'b0;
    checks++;
    if (busy !== 1'b0 || f_cnt !== 5'd0) begin
      failures++; $display("FAIL idle_discard_state: busy=%0b fifo_cnt=%0d want 0/0", busy, f_cnt);
    end
  endtask

  task automatic test_two_lines();
    int n;
    apply_reset();
    stream_beats(0, 2 * LINE_W, 0, n);
    checks++;
    if (n !== LINE_W) begin
      failures++; $display("FAIL two_lines_count: got %0d want %0d", n, LINE_W);
    end
    #1;
    checks++;
    if ({fifo_rd_en, fifo_wr_en, busy} !== 3'b001) begin
      failures++; $display("FAIL gap_no_read: got rd/wr/busy %03b want 001", {fifo_rd_en, fifo_wr_en, busy});
    end
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b0 || f_cnt !== 5'(LINE_W)) begin
      failures++; $display("FAIL gap_stall: out_vld=%0b fifo_cnt=%0d want 0/%0d", out_vld, f_cnt, LINE_W);
    end
    checks++;
    if ({err_ovf, err_udf} !== 2'b00) begin
      failures++; $display("FAIL two_lines_err: got %02b want 00", {err_ovf, err_udf});
    end
  endtask

  task automatic test_full_frame();
    int n;
    int idle_seen;
    int cyc;
    int exp_lc;
`ifdef SOBEL_LDC_LINE_CNT_EN
    exp_lc = FRAME_H;
`else
    exp_lc = 0;
`endif
    apply_reset();
    stream_beats(0, FRAME_H * LINE_W, 0, n);
    checks++;
    if (n !== (FRAME_H - 1) * LINE_W) begin
      failures++; $display("FAIL frame_count: got %0d want %0d", n, (FRAME_H - 1) * LINE_W);
    end
    in_vld = 1'b1; in_sof = 1'b0; in_data = 8'h77;
    #1;
    checks++;
    if ({in_rdy, fifo_rd_en, fifo_wr_en, busy} !== 4'b0101) begin
      failures++; $display("FAIL flush_comb: got rdy/rd/wr/busy %04b want 0101", {in_rdy, fifo_rd_en, fifo_wr_en, busy});
    end
    idle_seen = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      if (fifo_rd_vld) idle_seen = 0;
      else idle_seen++;
      @(negedge clk);
      cyc++;
    end
    in_vld = 1'b0;
    checks++;
    if (cyc >= 200) begin
      failures++; $display("FAIL flush_timeout: busy=%0b after %0d cycles want 0", busy, cyc);
    end
    checks++;
    if (idle_seen !== FLUSH_IDLE) begin
      failures++; $display("FAIL flush_idle_len: got %0d want %0d", idle_seen, FLUSH_IDLE);
    end
    checks++;
    if (f_cnt !== 5'd0 || {err_ovf, err_udf} !== 2'b00) begin
      failures++; $display("FAIL frame_end: fifo_cnt=%0d err=%02b want 0/00", f_cnt, {err_ovf, err_udf});
    end
    checks++;
    if (line_cnt !== 16'(exp_lc)) begin
      failures++; $display("FAIL frame_line_cnt: got %0d want %0d", line_cnt, exp_lc);
    end
  endtask

  task automatic test_premature_sof();
    int n;
    int cyc;
    apply_reset();
    stream_beats(0, 3 * LINE_W + 5, 0, n);
    checks++;
    if (n !== 2 * LINE_W + 5) begin
      failures++; $display("FAIL pre_count: got %0d want %0d", n, 2 * LINE_W + 5);
    end
    in_vld = 1'b1; in_sof = 1'b1; in_data = pix(8'h80, 0);
    #1;
    checks++;
    if ({in_rdy, fifo_wr_en} !== 2'b00) begin
      failures++; $display("FAIL pre_refuse: got rdy/wr %02b want 00", {in_rdy, fifo_wr_en});
    end
    cyc = 0;
    @(negedge clk);
    checks++;
    if ({busy, in_rdy, fifo_rd_en} !== 3'b101) begin
      failures++; $display("FAIL pre_flush: got busy/rdy/rd %03b want 101", {busy, in_rdy, fifo_rd_en});
    end
    while (busy === 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 200 || f_cnt !== 5'd0) begin
      failures++; $display("FAIL pre_drain: cycles=%0d fifo_cnt=%0d want <200/0", cyc, f_cnt);
    end
    checks++;
    if ({in_rdy, fifo_wr_en} !== 2'b11) begin
      failures++; $display("FAIL pre_sof_accept: got rdy/wr %02b want 11", {in_rdy, fifo_wr_en});
    end
    // The held sof beat is beat 0 of the new frame; continue from beat 1.
    stream_beats(1, 2 * LINE_W, 8'h80, n);
    checks++;
    if (n !== LINE_W) begin
      failures++; $display("FAIL pre_refill_count: got %0d want %0d", n, LINE_W);
    end
  endtask

  task automatic test_underflow();
    int n;
    apply_reset();
    stream_beats(0, LINE_W + 2, 0, n);
    force_rd_inv = 1'b1; in_vld = 1'b1; in_sof = 1'b0; in_data = pix(0, LINE_W + 2);
    #1;
    checks++;
    if ({fifo_wr_en, fifo_rd_en} !== 2'b11) begin
      failures++; $display("FAIL udf_strobes: got wr/rd %02b want 11", {fifo_wr_en, fifo_rd_en});
    end
    @(negedge clk);
    in_vld = 1'b0; force_rd_inv = 1'b0;
    checks++;
    if ({err_udf, out_vld} !== 2'b10) begin
      failures++; $display("FAIL udf_flag: got udf/out_vld %02b want 10", {err_udf, out_vld});
    end
    checks++;
    if (f_cnt !== 5'(LINE_W + 1)) begin
      failures++; $display("FAIL udf_write: fifo_cnt=%0d want %0d", f_cnt, LINE_W + 1);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_udf !== 1'b0) begin
      failures++; $display("FAIL udf_clear: got %0b want 0", err_udf);
    end
    err_clr = 1'b1; force_rd_inv = 1'b1; in_vld = 1'b1; in_data = pix(0, LINE_W + 3);
    @(negedge clk);
    err_clr = 1'b0; force_rd_inv = 1'b0; in_vld = 1'b0;
    checks++;
    if (err_udf !== 1'b1) begin
      failures++; $display("FAIL udf_set_wins: got %0b want 1", err_udf);
    end
    @(negedge clk);
    checks++;
    if ({err_udf, err_ovf} !== 2'b10) begin
      failures++; $display("FAIL udf_sticky: got udf/ovf %02b want 10", {err_udf, err_ovf});
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    @(negedge clk);
    in_vld = 1'b1; in_sof = 1'b1; in_data = 8'h00;
    @(negedge clk);
    in_sof = 1'b0; in_data = 8'h01; force_full = 1'b1;
    #1;
    checks++;
    if ({fifo_wr_en, err_ovf} !== 2'b10) begin
      failures++; $display("FAIL ovf_wr_ungated: got wr/ovf %02b want 10", {fifo_wr_en, err_ovf});
    end
    @(negedge clk);
    in_vld = 1'b0; force_full = 1'b0;
    checks++;
    if ({err_ovf, busy} !== 2'b11) begin
      failures++; $display("FAIL ovf_flag: got ovf/busy %02b want 11", {err_ovf, busy});
    end
    @(negedge clk);
    checks++;
    if (err_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky: got %0b want 1", err_ovf);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_clear: got %0b want 0", err_ovf);
    end
  endtask

  task automatic test_reset_mid_stream();
    int n;
    apply_reset();
    stream_beats(0, LINE_W + 3, 0, n);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_cur, out_prev} !== '0 || {out_vld, out_eol, busy, err_ovf, err_udf} !== 5'b0) begin
      failures++; $display("FAIL midrst_regs: cur=%0h prev=%0h flags=%05b want 0/0/00000",
                           out_cur, out_prev, {out_vld, out_eol, busy, err_ovf, err_udf});
    end
    checks++;
    if (line_cnt !== 16'd0 || {in_rdy, fifo_wr_en, fifo_rd_en} !== 3'b100) begin
      failures++; $display("FAIL midrst_comb: line_cnt=%0d rdy/wr/rd=%03b want 0/100",
                           line_cnt, {in_rdy, fifo_wr_en, fifo_rd_en});
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_sof = 1'b0; in_data = '0; err_clr = 1'b0;
    force_rd_inv = 1'b0; force_full = 1'b0;
    test_reset();
    test_two_lines();
    test_full_frame();
    test_premature_sof();
    test_underflow();
    test_overflow();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
